// File: rtl/axis_pdm_mic_emulator.sv
// AXI-Stream to DDR PDM transmitter: emulates pairs of MEMS microphones sharing a data line,
// fed from a small elastic FIFO that falls back to a 50%-density silence pattern when starved.
module axis_pdm_mic_emulator #(
  parameter int unsigned NUM_MIC_PAIRS    = 4,
  parameter int unsigned AXI_STREAM_BYTES = 1,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                            pdm_clk,
  input  logic                            io_reset,
  input  logic                            enable,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [8*AXI_STREAM_BYTES-1:0]   s_axis_tdata,
  output logic [NUM_MIC_PAIRS-1:0]        pdm_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underflow,
  input  logic                            underflow_clr,
  output logic [15:0]                     underflow_count
);

  localparam int unsigned SLOT_W = 2 * NUM_MIC_PAIRS;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LW     = AW + 1;

  logic [SLOT_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [SLOT_W-1:0]        slot;
  logic                     idle_t;
  logic [NUM_MIC_PAIRS-1:0] gnd_bits_c;
  logic [NUM_MIC_PAIRS-1:0] vdd_bits_c;
  logic [NUM_MIC_PAIRS-1:0] rise_q;
  logic [NUM_MIC_PAIRS-1:0] fall_q;
  logic                     push_c;
  logic                     pop_c;
  logic                     starve_c;
  logic                     unused_tdata;

  // Upper tdata bits beyond the mic slots are intentionally dropped.
  assign unused_tdata = ^s_axis_tdata;

  assign s_axis_tready = (fifo_level != LW'(FIFO_DEPTH)) && !io_reset;
  assign push_c        = s_axis_tvalid && s_axis_tready;
  assign pop_c         = enable && (fifo_level != '0);
  assign starve_c      = enable && (fifo_level == '0);

  // Beat storage; contents are don't-care until written, so no reset.
  always_ff @(posedge pdm_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= s_axis_tdata[SLOT_W-1:0];
    end
  end

  always_ff @(posedge pdm_clk or posedge io_reset) begin
    if (io_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level <= fifo_level + LW'(push_c) - LW'(pop_c);
    end
  end

  // Slot register: head beat when available, otherwise alternating all-0/all-1 silence.
  always_ff @(posedge pdm_clk or posedge io_reset) begin
    if (io_reset) begin
      slot   <= '0;
      idle_t <= 1'b0;
    end else if (pop_c) begin
      slot <= mem[rd_ptr];
    end else begin
      slot   <= {SLOT_W{idle_t}};
      idle_t <= ~idle_t;
    end
  end

  // Clear takes priority over a same-edge starvation increment.
  always_ff @(posedge pdm_clk or posedge io_reset) begin
    if (io_reset) begin
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else if (underflow_clr) begin
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else if (starve_c) begin
      underflow <= 1'b1;
      if (underflow_count != 16'hFFFF) begin
        underflow_count <= underflow_count + 16'd1;
      end
    end
  end

  always_comb begin
    gnd_bits_c = '0;
    vdd_bits_c = '0;
    for (int i = 0; i < int'(NUM_MIC_PAIRS); i++) begin
      gnd_bits_c[i] = slot[2*i+1];
      vdd_bits_c[i] = slot[2*i];
    end
  end

  // DDR output without clock muxing: each edge register stores its bit XORed with the
  // other register, so rise_q ^ fall_q shows VDD after rising edges and GND after falling.
  always_ff @(posedge pdm_clk or posedge io_reset) begin
    if (io_reset) begin
      rise_q <= '0;
    end else begin
      rise_q <= vdd_bits_c ^ fall_q;
    end
  end

  always_ff @(negedge pdm_clk or posedge io_reset) begin
    if (io_reset) begin
      fall_q <= '0;
    end else begin
      fall_q <= gnd_bits_c ^ rise_q;
    end
  end

  assign pdm_data = rise_q ^ fall_q;

endmodule

// File: tb/tb_axis_pdm_mic_emulator.sv
// Bench for axis_pdm_mic_emulator: reference model with a beat scoreboard, a capture-side
// check of GND/VDD bits on every edge, plus table-driven and hand-written sequences.
module tb_axis_pdm_mic_emulator;

  localparam int unsigned NP    = 4;
  localparam int unsigned BYTES = 2;
  localparam int unsigned DEPTH = 16;

  logic          pdm_clk;
  logic          io_reset;
  logic          enable;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [15:0]   s_axis_tdata;
  logic [NP-1:0] pdm_data;
  logic [4:0]    fifo_level;
  logic          underflow;
  logic          underflow_clr;
  logic [15:0]   underflow_count;

  axis_pdm_mic_emulator #(
    .NUM_MIC_PAIRS(NP), .AXI_STREAM_BYTES(BYTES), .FIFO_DEPTH(DEPTH)
  ) dut (
    .pdm_clk(pdm_clk), .io_reset(io_reset), .enable(enable),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .pdm_data(pdm_data), .fifo_level(fifo_level), .underflow(underflow),
    .underflow_clr(underflow_clr), .underflow_count(underflow_count)
  );

  initial pdm_clk = 1'b0;
  always #5 pdm_clk = ~pdm_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] gnd_of(input logic [7:0] s);
    for (int i = 0; i < int'(NP); i++) gnd_of[i] = s[2*i+1];
  endfunction

  function automatic logic [NP-1:0] vdd_of(input logic [7:0] s);
    for (int i = 0; i < int'(NP); i++) vdd_of[i] = s[2*i];
  endfunction

  // Reference model state
  logic [7:0] sb_q[$];
  int         m_level;
  logic       m_t;
  logic       m_uf;
  int         m_cnt;
  logic [7:0] cur_slot;
  logic [7:0] prev_slot;
  logic       acc;
  logic [7:0] drv_exp;

  always @(posedge pdm_clk) begin
    logic       m_push;
    logic       m_pop;
    logic [7:0] ns;
    if (io_reset) begin
      sb_q.delete();
      m_level = 0; m_t = 1'b0; m_uf = 1'b0; m_cnt = 0;
      cur_slot = 8'h00; prev_slot = 8'h00; acc = 1'b0;
    end else begin
      m_push = s_axis_tvalid && (m_level != int'(DEPTH));
      m_pop  = enable && (m_level != 0);
      if (m_pop) begin
        ns = sb_q.pop_front();
      end else begin
        ns  = {8{m_t}};
        m_t = ~m_t;
      end
      if (m_push) sb_q.push_back(drv_exp);
      if (underflow_clr) begin
        m_uf = 1'b0; m_cnt = 0;
      end else if (enable && m_level == 0) begin
        m_uf = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      m_level   = m_level + int'(m_push) - int'(m_pop);
      prev_slot = cur_slot;
      cur_slot  = ns;
      acc       = m_push;
      #2;
      if (!io_reset) begin
        chk("vdd_bits", 32'(pdm_data), 32'(vdd_of(prev_slot)));
        chk("fifo_level", 32'(fifo_level), 32'(m_level));
        chk("tready", 32'(s_axis_tready), 32'(m_level != int'(DEPTH)));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("underflow_count", 32'(underflow_count), 32'(m_cnt));
      end
    end
  end

  always @(negedge pdm_clk) begin
    #2;
    if (!io_reset) chk("gnd_bits", 32'(pdm_data), 32'(gnd_of(cur_slot)));
  end

  task automatic step(input logic v, input logic [15:0] d, input logic [7:0] e,
                      input logic en, input logic clr);
    @(negedge pdm_clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    drv_exp       = e;
    enable        = en;
    underflow_clr = clr;
  endtask

  typedef struct {
    logic [15:0] tdata;
    logic [7:0]  exp_beat;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   sent;
    vecs[0] = '{16'h0002, 8'h02};
    vecs[1] = '{16'h0001, 8'h01};
    vecs[2] = '{16'h00AA, 8'hAA};
    vecs[3] = '{16'h0055, 8'h55};
    vecs[4] = '{16'hFF00, 8'h00};
    vecs[5] = '{16'h9E34, 8'h34};

    io_reset = 1'b1; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    underflow_clr = 1'b0; drv_exp = '0;
    repeat (2) @(posedge pdm_clk);
    #3;
    chk("rst_pdm", 32'(pdm_data), 32'h0);
    chk("rst_tready", 32'(s_axis_tready), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_uf", 32'(underflow), 32'h0);
    chk("rst_cnt", 32'(underflow_count), 32'h0);
    @(negedge pdm_clk);
    io_reset = 1'b0;

    // Idle with enable low: silence pattern, no underflow
    repeat (8) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);

    // Three starved slots, prime two beats, then stream the table back-to-back
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, vecs[i].tdata, vecs[i].exp_beat, 1'b0, 1'b0);
    for (int i = 2; i < 6; i++) step(1'b1, vecs[i].tdata, vecs[i].exp_beat, 1'b1, 1'b0);
    repeat (2) step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    #2;
    chk("prime_underflow_count", 32'(underflow_count), 32'd3);

    // Fill to full with enable low, then drain
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, {8'hC3, 8'(sent * 7 + 1)}, 8'(sent * 7 + 1), 1'b0, 1'b0);
      @(posedge pdm_clk);
      #1;
      if (acc) sent++;
    end
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    #2;
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_tready", 32'(s_axis_tready), 32'h0);
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    @(posedge pdm_clk);
    #3;
    chk("after_pop_tready", 32'(s_axis_tready), 32'h1);
    chk("after_pop_level", 32'(fifo_level), 32'd15);
    repeat (18) step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    #2;
    chk("drained_level", 32'(fifo_level), 32'd0);

    // Long starvation saturates the counter, then a one-cycle clear
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    repeat (70000) @(negedge pdm_clk);
    #2;
    chk("sat_count", 32'(underflow_count), 32'hFFFF);
    chk("sat_flag", 32'(underflow), 32'h1);
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    @(posedge pdm_clk);
    #3;
    chk("clr_count", 32'(underflow_count), 32'h0);
    chk("clr_flag", 32'(underflow), 32'h0);

    // Reset with ten beats buffered
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h5A00 + i), 8'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    #1;
    io_reset = 1'b1;
    #1;
    chk("async_rst_pdm", 32'(pdm_data), 32'h0);
    chk("async_rst_tready", 32'(s_axis_tready), 32'h0);
    chk("async_rst_level", 32'(fifo_level), 32'h0);
    repeat (2) @(posedge pdm_clk);
    @(negedge pdm_clk);
    io_reset = 1'b0;
    @(negedge pdm_clk);
    #2;
    chk("post_rst_gnd0", 32'(pdm_data), 32'h0);
    @(posedge pdm_clk);
    #3;
    chk("post_rst_vdd0", 32'(pdm_data), 32'h0);
    @(negedge pdm_clk);
    #2;
    chk("post_rst_gnd1", 32'(pdm_data), 32'hF);
    repeat (4) step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    repeat (2) @(negedge pdm_clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
